// File: rtl/iir_pkg.sv
// Shared types, widths and fixed-point conversions for the DF-I IIR sequencer.
package iir_pkg;

  localparam int W    = 16;
  localparam int FRAC = 11;
  localparam int ACCW = 20;

  localparam logic [W-1:0] SM_MAX = 16'h7FFF;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  // Sign-magnitude to two's complement, sign-extended to the accumulator width.
  // A magnitude of zero maps to zero whatever the sign bit says.
  function automatic logic signed [ACCW-1:0] sm_to_tc(input logic [W-1:0] sm);
    logic signed [ACCW-1:0] mag;
    mag = {{(ACCW-W+1){1'b0}}, sm[W-2:0]};
    return sm[W-1] ? -mag : mag;
  endfunction

  // Two's complement accumulator to sign-magnitude, clamped to +/-SM_MAX.
  // Zero always comes out with a clear sign bit.
  function automatic logic [W-1:0] tc_to_sm_sat(input logic signed [ACCW-1:0] v);
    logic signed [ACCW-1:0] lim;
    logic signed [ACCW-1:0] mag;
    logic [W-1:0]           res;
    lim = {{(ACCW-W+1){1'b0}}, SM_MAX[W-2:0]};
    mag = v[ACCW-1] ? -v : v;
    if (v > lim)
      res = SM_MAX;
    else if (v < -lim)
      res = {1'b1, SM_MAX[W-2:0]};
    else
      res = {v[ACCW-1], mag[W-2:0]};
    return res;
  endfunction

endpackage

// File: rtl/iir_df1_sequencer_if.sv
// Sample stream, coefficient write port and shared-multiplier operand bus.
interface iir_df1_sequencer_if;
  import iir_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         coef_we;
  logic [2:0]   coef_addr;
  logic [W-1:0] coef_data;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic [W-1:0] mul_p;

  // Environment side: sample source, sink, coefficient writer and multiplier.
  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data, mul_p,
    input  in_ready, out_valid, out_data, mul_a, mul_b
  );

  // Filter side.
  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data, mul_p,
    output in_ready, out_valid, out_data, mul_a, mul_b
  );

endinterface

// File: rtl/iir_coef_bank.sv
// Coefficient register file: b0..b(NB-1) at 0..NB-1, a1..aNA at NB..NB+NA-1.
// Read address is the tap counter, so tap k reads its own coefficient directly.
module iir_coef_bank
  import iir_pkg::*;
#(
  parameter int NB = 3,
  parameter int NA = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [2:0]   addr,
  input  logic [W-1:0] data,
  input  logic [2:0]   raddr,
  output logic [W-1:0] rdata
);

  localparam int NT = NB + NA;

  logic [W-1:0] coef [NT];

  // Write port; addresses beyond the last tap match no entry and are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NT; i++) coef[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NT; i++)
        if (addr == 3'(i)) coef[i] <= data;
    end
  end

  // Combinational read port indexed by the tap counter.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NT; i++)
      if (raddr == 3'(i)) rdata = coef[i];
  end

endmodule

// File: rtl/iir_df1_sequencer.sv
// Time-multiplexed direct-form-I IIR section driving an external shared
// sign-magnitude multiplier: one tap per cycle, wide accumulate, saturated
// sign-magnitude output over valid/ready.
module iir_df1_sequencer
  import iir_pkg::*;
#(
  parameter int NB = 3,
  parameter int NA = 2
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 clr,
  iir_df1_sequencer_if.slave  bus
);

  localparam logic [2:0] NB_K   = 3'(NB);
  localparam logic [2:0] LAST_K = 3'(NB + NA - 1);

  state_t                 state, state_nxt;
  logic [2:0]             k;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] term;
  logic signed [ACCW-1:0] sum;
  logic [W-1:0]           x [NB];
  logic [W-1:0]           y [NA];   // y[0] holds y[n-1]
  logic [W-1:0]           out_reg;
  logic [W-1:0]           coef_rd;
  logic                   accept;
  logic                   last;
  logic                   coef_we_ok;

  assign accept     = (state == IDLE) && bus.in_valid;
  assign last       = (state == MAC) && (k == LAST_K);
  assign coef_we_ok = bus.coef_we && (state == IDLE) && !clr;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = out_reg;

  iir_coef_bank #(.NB(NB), .NA(NA)) u_coef (
    .clk   (clk),
    .rst   (rst),
    .we    (coef_we_ok),
    .addr  (bus.coef_addr),
    .data  (bus.coef_data),
    .raddr (k),
    .rdata (coef_rd)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: accept -> MAC for NB+NA taps -> OUT until taken; clr wins.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = MAC;
      MAC:     if (k == LAST_K)   state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // Operand select: feedforward taps pair b[k] with x[k], feedback taps pair
  // a[k-NB+1] with y[k-NB+1]; both operands idle at zero outside MAC.
  always_comb begin
    bus.mul_a = '0;
    bus.mul_b = '0;
    if (state == MAC) begin
      bus.mul_a = coef_rd;
      for (int i = 0; i < NB; i++)
        if (k == 3'(i)) bus.mul_b = x[i];
      for (int j = 0; j < NA; j++)
        if (k == 3'(NB + j)) bus.mul_b = y[j];
    end
  end

  // Product into the accumulator; feedback taps subtract.
  always_comb begin
    term = sm_to_tc(bus.mul_p);
    sum  = (k >= NB_K) ? (acc - term) : (acc + term);
  end

  // Delay lines, accumulator, tap counter and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) x[i] <= '0;
      for (int j = 0; j < NA; j++) y[j] <= '0;
      acc     <= '0;
      k       <= '0;
      out_reg <= '0;
    end else if (clr) begin
      for (int i = 0; i < NB; i++) x[i] <= '0;
      for (int j = 0; j < NA; j++) y[j] <= '0;
      acc <= '0;
      k   <= '0;
    end else begin
      if (accept) begin
        for (int i = NB - 1; i > 0; i--) x[i] <= x[i-1];
        x[0] <= bus.in_data;
        acc  <= '0;
        k    <= '0;
      end
      if (state == MAC) begin
        acc <= sum;
        k   <= k + 3'd1;
        if (last) out_reg <= tc_to_sm_sat(sum);
      end
      if ((state == OUT) && bus.out_ready) begin
        for (int j = NA - 1; j > 0; j--) y[j] <= y[j-1];
        y[0] <= out_reg;
      end
    end
  end

endmodule

// File: tb/tb_iir_df1_sequencer.sv
// Bench for iir_df1_sequencer: models the shared multiplier, runs directed
// filter scenarios and a randomized run against a behavioural reference.
module tb_iir_df1_sequencer;
  import iir_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  iir_df1_sequencer_if bus ();

  iir_df1_sequencer #(.NB(3), .NA(2)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: coefficients b0,b1,b2,a1,a2 and the delay lines.
  logic [15:0] mb [5];
  logic [15:0] mx [3];
  logic [15:0] my [2];

  // Shared multiplier: magnitude product truncated to 11 fraction bits and
  // clamped; a zero product keeps the XOR sign (may be negative zero).
  function automatic logic [15:0] ext_mul(input logic [15:0] a, input logic [15:0] b);
    longint m;
    m = (longint'(a[14:0]) * longint'(b[14:0])) >>> FRAC;
    if (m > 32767) m = 32767;
    return {a[15] ^ b[15], 15'(m)};
  endfunction

  always_comb bus.mul_p = ext_mul(bus.mul_a, bus.mul_b);

  function automatic int sm_val(input logic [15:0] v);
    return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
  endfunction

  function automatic logic [15:0] to_sm(input int v);
    if (v > 32767)  return 16'h7FFF;
    if (v < -32767) return 16'hFFFF;
    if (v < 0)      return {1'b1, 15'(-v)};
    return {1'b0, 15'(v)};
  endfunction

  // y[n] = sum b_i*x[n-i] - sum a_j*y[n-j], each product from the multiplier.
  task automatic model_sample(input logic [15:0] din, output logic [15:0] dout);
    int acc;
    mx[2] = mx[1]; mx[1] = mx[0]; mx[0] = din;
    acc = 0;
    for (int i = 0; i < 3; i++) acc += sm_val(ext_mul(mb[i], mx[i]));
    for (int j = 0; j < 2; j++) acc -= sm_val(ext_mul(mb[3+j], my[j]));
    dout = to_sm(acc);
    my[1] = my[0]; my[0] = dout;
  endtask

  task automatic model_clear_lines();
    for (int i = 0; i < 3; i++) mx[i] = '0;
    for (int j = 0; j < 2; j++) my[j] = '0;
  endtask

  task automatic write_coef(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    bus.coef_we = 1'b1; bus.coef_addr = addr; bus.coef_data = data;
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
    if (addr < 3'd5) mb[addr] = data;
  endtask

  task automatic set_coefs(input logic [15:0] b0, b1, b2, a1, a2);
    write_coef(3'd0, b0); write_coef(3'd1, b1); write_coef(3'd2, b2);
    write_coef(3'd3, a1); write_coef(3'd4, a2);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_clear_lines();
  endtask

  // One sample through the DUT. mode 1: coefficient write in the accept cycle;
  // mode 2: coefficient write in the first MAC cycle. lat = edges from accept
  // to out_valid (20 means it never came).
  task automatic do_sample(input logic [15:0] din, input int mode,
                           input logic [2:0] wa, input logic [15:0] wd,
                           input int stall, output logic [15:0] dout, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = din;
    if (mode == 1) begin
      bus.coef_we = 1'b1; bus.coef_addr = wa; bus.coef_data = wd;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.coef_we = 1'b0;
    if (mode == 2) begin
      bus.coef_we = 1'b1; bus.coef_addr = wa; bus.coef_data = wd;
    end
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      bus.coef_we = 1'b0;
      lat++;
      if (bus.out_valid) break;
    end
    dout = bus.out_data;
    repeat (stall) @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 16'h0)  begin n_fail++; $display("FAIL reset_out_data: got %h want 0000", bus.out_data); end
    n_checks++; if (bus.mul_a !== 16'h0)     begin n_fail++; $display("FAIL reset_mul_a: got %h want 0000", bus.mul_a); end
    n_checks++; if (bus.mul_b !== 16'h0)     begin n_fail++; $display("FAIL reset_mul_b: got %h want 0000", bus.mul_b); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) mb[i] = '0;
    model_clear_lines();
  endtask

  task automatic test_passthrough();
    logic [15:0] d;
    int lat;
    set_coefs(16'h0800, 16'h0, 16'h0, 16'h0, 16'h0);
    pulse_clr();
    do_sample(16'h1400, 0, 3'd0, 16'h0, 0, d, lat);
    n_checks++; if (lat !== 5)       begin n_fail++; $display("FAIL pass_latency: got %0d want 5", lat); end
    n_checks++; if (d !== 16'h1400)  begin n_fail++; $display("FAIL pass_pos: got %h want 1400", d); end
    do_sample(16'h9000, 0, 3'd0, 16'h0, 0, d, lat);
    n_checks++; if (lat !== 5)       begin n_fail++; $display("FAIL pass_latency2: got %0d want 5", lat); end
    n_checks++; if (d !== 16'h9000)  begin n_fail++; $display("FAIL pass_neg: got %h want 9000", d); end
  endtask

  task automatic test_fir_impulse();
    logic [15:0] ins [4];
    logic [15:0] exp [4];
    logic [15:0] d;
    int lat;
    ins = '{16'h0800, 16'h0000, 16'h0000, 16'h0000};
    exp = '{16'h0800, 16'h0800, 16'h0800, 16'h0000};
    set_coefs(16'h0800, 16'h0800, 16'h0800, 16'h0, 16'h0);
    pulse_clr();
    for (int i = 0; i < 4; i++) begin
      do_sample(ins[i], 0, 3'd0, 16'h0, i, d, lat);
      n_checks++; if (d !== exp[i]) begin n_fail++; $display("FAIL fir_impulse[%0d]: got %h want %h", i, d, exp[i]); end
    end
  endtask

  task automatic feedback_seq(input string tag);
    logic [15:0] exp [4];
    logic [15:0] d;
    int lat;
    exp = '{16'h0800, 16'h0400, 16'h0200, 16'h0100};
    for (int i = 0; i < 4; i++) begin
      do_sample((i == 0) ? 16'h0800 : 16'h0000, 0, 3'd0, 16'h0, 0, d, lat);
      n_checks++; if (d !== exp[i]) begin n_fail++; $display("FAIL %s[%0d]: got %h want %h", tag, i, d, exp[i]); end
    end
  endtask

  task automatic test_feedback();
    set_coefs(16'h0800, 16'h0, 16'h0, 16'h8400, 16'h0);
    pulse_clr();
    feedback_seq("feedback");
  endtask

  task automatic test_saturation();
    logic [15:0] d;
    int lat;
    set_coefs(16'h0800, 16'h0800, 16'h0, 16'h0, 16'h0);
    pulse_clr();
    do_sample(16'h7800, 0, 3'd0, 16'h0, 0, d, lat);
    n_checks++; if (d !== 16'h7800) begin n_fail++; $display("FAIL sat_first: got %h want 7800", d); end
    do_sample(16'h7800, 0, 3'd0, 16'h0, 0, d, lat);
    n_checks++; if (d !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos: got %h want 7FFF", d); end
    do_sample(16'hF800, 0, 3'd0, 16'h0, 0, d, lat);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL sat_zero: got %h want 0000", d); end
    do_sample(16'hF800, 0, 3'd0, 16'h0, 0, d, lat);
    n_checks++; if (d !== 16'hFFFF) begin n_fail++; $display("FAIL sat_neg: got %h want FFFF", d); end
  endtask

  task automatic test_backpressure();
    logic [15:0] d;
    int lat;
    set_coefs(16'h0800, 16'h0, 16'h0, 16'h0, 16'h0);
    pulse_clr();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 16'h0C00;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid) break;
    end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL bp_latency: got %0d want 5", lat); end
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        bus.coef_we = 1'b1; bus.coef_addr = 3'd0; bus.coef_data = 16'h1000;
      end
      @(posedge clk); #1;
      bus.coef_we = 1'b0;
      n_checks++; if (bus.out_data !== 16'h0C00) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h want 0C00", c, bus.out_data); end
      n_checks++; if (bus.in_ready !== 1'b0)     begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, bus.in_ready); end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid: got %b want 0", bus.out_valid); end
    do_sample(16'h0C00, 0, 3'd0, 16'h0, 0, d, lat);
    n_checks++; if (d !== 16'h0C00) begin n_fail++; $display("FAIL bp_coef_dropped: got %h want 0C00", d); end
  endtask

  task automatic test_abort_clr();
    logic [15:0] d;
    int lat;
    set_coefs(16'h0800, 16'h0, 16'h0, 16'h8400, 16'h0);
    pulse_clr();
    do_sample(16'h0800, 0, 3'd0, 16'h0, 0, d, lat);
    n_checks++; if (d !== 16'h0800) begin n_fail++; $display("FAIL clr_pre: got %h want 0800", d); end
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 16'h0400;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_clear_lines();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1)  begin n_fail++; $display("FAIL clr_in_ready: got %b want 1", bus.in_ready); end
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_discard: got %b want 0", bus.out_valid); end
    feedback_seq("clr_impulse");
  endtask

  task automatic test_abort_rst();
    logic [15:0] d;
    int lat;
    pulse_clr();
    do_sample(16'h1400, 0, 3'd0, 16'h0, 0, d, lat);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 16'h0800;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 16'h0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0000", bus.out_data); end
    n_checks++; if (bus.mul_a !== 16'h0)    begin n_fail++; $display("FAIL rst_mul_a: got %h want 0000", bus.mul_a); end
    n_checks++; if (bus.mul_b !== 16'h0)    begin n_fail++; $display("FAIL rst_mul_b: got %h want 0000", bus.mul_b); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) mb[i] = '0;
    model_clear_lines();
    do_sample(16'h0800, 0, 3'd0, 16'h0, 0, d, lat);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL rst_coefs_cleared: got %h want 0000", d); end
  endtask

  task automatic test_random();
    logic [15:0] d, exp, din, wd;
    logic [2:0]  wa;
    int lat, mode;
    for (int i = 0; i < 5; i++)
      write_coef(3'(i), {1'($urandom), 3'b000, 12'($urandom)});
    pulse_clr();
    for (int n = 0; n < 40; n++) begin
      mode = int'($urandom_range(0, 3));
      wa   = 3'($urandom_range(0, 7));
      wd   = {1'($urandom), 3'b000, 12'($urandom)};
      din  = $urandom_range(0, 1) ? {1'($urandom), 2'b00, 13'($urandom)} : 16'($urandom);
      if (mode == 1 && wa < 3'd5) mb[wa] = wd;
      model_sample(din, exp);
      do_sample(din, (mode == 3) ? 0 : mode, wa, wd, int'($urandom_range(0, 3)), d, lat);
      n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want 5", n, lat); end
      n_checks++; if (d !== exp) begin n_fail++; $display("FAIL rand_out[%0d]: in %h got %h want %h", n, din, d, exp); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    test_reset();
    test_passthrough();
    test_fir_impulse();
    test_feedback();
    test_saturation();
    test_backpressure();
    test_abort_clr();
    test_abort_rst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iir_df1_sequencer.md
Name: iir_df1_sequencer

Overview:
Time-multiplexed direct-form-I IIR section that sits around the shared sign-magnitude fixed-point multiplier. It feeds the multiplier's two operand inputs and consumes its product. For each accepted input sample it steps through all feedforward and feedback taps, one product per cycle. It accumulates in a wide two's-complement register and emits one saturated sign-magnitude output sample over a valid/ready handshake.

Parameters:
NB, 3, number of feedforward taps b0..b(NB-1).
NA, 2, number of feedback taps a1..aNA.
W, 16, sample/coefficient width; sign-magnitude, bit15 sign, bits14:11 integer, bits10:0 fraction.
ACCW, 20, accumulator width, two's complement, 11 fraction bits.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous, active-high reset.
clr  in  1  synchronous clear: delay lines, accumulator and FSM to IDLE; coefficients kept.
coef_we  in  1  coefficient write strobe.
coef_addr  in  3  0..NB-1 select b0..b(NB-1); NB..NB+NA-1 select a1..aNA.
coef_data  in  16  coefficient value, sign-magnitude.
in_valid  in  1  input sample valid.
in_ready  out  1  block can accept a sample.
in_data  in  16  input sample, sign-magnitude.
out_valid  out  1  output sample valid.
out_ready  in  1  downstream accepts output.
out_data  out  16  output sample, sign-magnitude.
mul_a  out  16  multiplier operand A, coefficient.
mul_b  out  16  multiplier operand B, data.
mul_p  in  16  multiplier product, sign-magnitude, combinational from mul_a and mul_b.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. Reset clears all registers: coefficients, x/y delay lines, accumulator and tap counter. Reset values: in_ready=1, out_valid=0, out_data=0, mul_a=0, mul_b=0. FSM resets to IDLE.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: shift the x line (x[k]<=x[k-1], x[0]<=in_data), clear acc, set k=0, go to MAC.
- MAC:
  - in_ready=0. Runs one tap per cycle for NB+NA cycles.
  - Operand selection: for k<NB, mul_a=b[k] and mul_b=x[k]. For k>=NB, mul_a=a[k-NB+1] and mul_b=y[k-NB+1].
  - The x[0] used is the newly shifted sample.
  - Each edge: convert mul_p to two's complement and sign-extend to ACCW. Invert the sign for feedback taps. Add to acc.
  - On the edge with k=NB+NA-1, the final sum is saturated and converted. The result is registered into out_data, and the FSM goes to OUT.
- OUT:
  - out_valid=1. out_data is held stable until out_ready.
  - On out_valid&out_ready: shift the y line (y[1]<=out_data, y[j]<=y[j-1]), go to IDLE.
- Latency: out_valid rises exactly NB+NA edges after the input-accept edge (5 cycles at defaults). Maximum throughput is one sample per NB+NA+2 cycles.
- Operand outputs: mul_a and mul_b are 0 outside MAC.
- Arithmetic:
  - A product with magnitude 0 counts as 0 regardless of its sign bit.
  - Saturation: if the final sum is above +32767/2048, out_data=16'h7FFF. If it is below -32767/2048, out_data=16'hFFFF.
  - Negative zero is never emitted: a zero result gives 16'h0000.
- Coefficient writes:
  - Accepted only in IDLE. Writes in MAC or OUT are dropped silently.
  - coef_addr >= NB+NA is ignored.
  - A write and a sample accept in the same IDLE cycle both take effect. The written coefficient is used by that sample's MAC.
- clr:
  - clr has priority over every other synchronous action. It aborts MAC or OUT, and the pending output is discarded.
  - Next cycle: out_valid=0, in_ready=1.
- Reset mid-MAC: all state clears immediately. The sample in flight is lost.

Decomposition:
- Shared package iir_pkg:
  - W, fraction bits FRAC=11, ACCW.
  - SM_MAX=16'h7FFF.
  - FSM state enum {IDLE, MAC, OUT}.
  - Conversion functions sm_to_tc and tc_to_sm_sat.
- Sub-module: iir_coef_bank, the coefficient register file with a write port and one combinational read port indexed by k. The delay lines and FSM stay in the top.
- The multiplier itself is instantiated by the parent, not inside this block.

Test Plan:
- Pass-through: b0=16'h0800 (1.0), other coefficients 0. Input 16'h1400 (2.5) -> out_data=16'h1400 with out_valid exactly 5 cycles after accept. Input 16'h9000 (-2.0) -> 16'h9000.
- FIR impulse: b0=b1=b2=16'h0800. Input sequence 1.0, 0, 0, 0 (16'h0800, then 0s) -> outputs 16'h0800, 16'h0800, 16'h0800, 16'h0000.
- Feedback: b0=16'h0800, a1=16'h8400 (-0.5), i.e. y=x+0.5*y[n-1]. Impulse 1.0 then zeros -> 16'h0800, 16'h0400, 16'h0200, 16'h0100.
- Saturation: b0=b1=16'h0800. Inputs 16'h7800 (15.0) twice -> second output 16'h7FFF. With inputs 16'hF800 twice -> 16'hFFFF.
- Backpressure: hold out_ready=0 for 10 cycles -> out_data stable, in_ready=0, a coefficient write in that window has no effect. Raise out_ready -> one transfer, in_ready=1 next cycle.
- Abort: assert rst asynchronously during MAC cycle 2 -> outputs reach reset values without a clock edge, coefficients read 0. Repeat with clr -> coefficients retained, delay lines zero, next impulse reproduces the first impulse response.
